shift_and_subtract_binary_divider: RTL and testbench
====================================================

Name: shift_and_subtract_binary_divider

Overview:
Sequential unsigned restoring divider, the inverse of the team's shift-and-add multiplier.
- Resolves one quotient bit per clock.
- Uses a start/busy/done handshake.
- Holds its results stable until the next accepted start.
- Sits beside the multiplier in the arithmetic datapath, so a multiply result can be divided back by either operand.

Parameters:
- N, 8, dividend and quotient width
- D, 8, divisor and remainder width (D <= N)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a division; sampled only when not busy
- dividend  input  N  unsigned dividend, sampled on the accepting edge
- divisor  input  D  unsigned divisor, sampled on the accepting edge
- busy  output  1  high while an iteration sequence is in progress
- done  output  1  single-cycle pulse: results valid
- quotient  output  N  unsigned quotient
- remainder  output  D  unsigned remainder
- div_by_zero  output  1  high with done when divisor was 0; held until next accepted start

Behaviour:
- Reset: clk and rst as stated above. rst forces state IDLE and clears busy, done, quotient, remainder, div_by_zero and all internal registers to 0. Reset mid-operation abandons the operation; no done is produced.
- States: IDLE, CALC.
- IDLE, start=1, divisor!=0 (edge k):
  - Load the quotient shift register with dividend and the partial remainder R (D+1 bits) with 0.
  - Load the iteration counter with N-1.
  - Set busy=1, clear div_by_zero, go to CALC.
- IDLE, start=1, divisor==0 (edge k):
  - Stay in IDLE with busy=0.
  - After edge k: done=1, quotient all ones, remainder=0, div_by_zero=1.
  - Latency is 1 cycle.
- CALC iteration (edges k+1 .. k+N):
  - trial = {R[D-1:0], Qsh[N-1]} - {1'b0, divisor}, computed D+1 bits wide.
  - If trial MSB is 0: R <= trial and shift 1 into the Qsh LSB.
  - Otherwise: R <= {R[D-1:0], Qsh[N-1]} and shift 0 into the Qsh LSB.
  - Qsh shifts left by 1 each iteration.
  - Counter decrements each iteration.
- Final iteration (counter==0, edge k+N):
  - quotient <= new Qsh, remainder <= new R[D-1:0].
  - busy <= 0, done <= 1, go to IDLE.
- Latency: done is high in the cycle after edge k+N, so N+1 edges from the start sample.
- done is high for exactly one cycle; it deasserts on the next edge unless a new zero-divisor start produces another pulse.
- quotient, remainder and div_by_zero hold their values from done until the next accepted start.
  - On an accepted non-zero start they are not cleared; they change only at the next done.
- start while busy=1 is ignored and has no effect on the operation in flight.
- start during the done cycle (state IDLE) is accepted, giving back-to-back operation with a throughput of one division per N+1 cycles.
- Dividend inputs may change freely after the accepting edge.
- Result guarantee: dividend = quotient*divisor + remainder, with remainder < divisor, for all divisor != 0.

Decomposition:
- Shared package div_pkg holds:
  - the state encoding constants (IDLE, CALC);
  - the default widths;
  - the zero-divisor quotient constant, all ones.
- One sub-module is natural: restoring_div_step.
  - Purely combinational.
  - Inputs: R, incoming dividend bit, divisor.
  - Outputs: next R and the quotient bit.
  - The top level holds the FSM, counter and registers.

Test Plan:
- N=D=8: dividend=100, divisor=7, start pulse -> done exactly 9 edges after the start edge; quotient=14, remainder=2, div_by_zero=0; busy high for 8 cycles.
- dividend=255, divisor=1 -> quotient=255, remainder=0. dividend=5, divisor=9 -> quotient=0, remainder=5. dividend=0, divisor=200 -> quotient=0, remainder=0.
- dividend=77, divisor=0 -> done 1 cycle after start, quotient=0xFF, remainder=0, div_by_zero=1, busy never high. A following 77/7 -> div_by_zero=0, quotient=11, remainder=0.
- Start 200/3; pulse start with 9/9 at edges k+3 and k+5 -> ignored; done gives quotient=66, remainder=2, and no second done follows.
- Start 100/7, assert rst at edge k+4 -> all outputs 0, no done. After release, 100/7 completes normally with 14, 2.
- Back-to-back: assert start with 50/6 in the done cycle of 100/7 -> second done 9 edges later with quotient=8, remainder=2. Then 2000 random operand pairs checked against the / and % reference.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the shift-and-subtract divider: state encoding,
// default operand widths and the quotient reported for a zero divisor.
package div_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam int DEF_N = 8;
  localparam int DEF_D = 8;

  // Wide enough for any practical N; the top level slices it to width.
  localparam logic [63:0] ZERO_DIV_QUOTIENT = {64{1'b1}};

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module restoring_div_step #(
  parameter int D = 8
) (
  input  logic [D:0]   rem_in,
  input  logic         in_bit,
  input  logic [D-1:0] divisor,
  output logic [D:0]   rem_out,
  output logic         q_bit
);

  logic [D:0] shifted;
  logic [D:0] trial;
  // The partial remainder stays below the divisor, so its top bit is always 0.
  logic       unused_rem_msb;

  assign unused_rem_msb = rem_in[D];

  // Trial subtraction; a clear MSB means the divisor fits.
  always_comb begin
    shifted = {rem_in[D-1:0], in_bit};
    trial   = shifted - {1'b0, divisor};
    if (trial[D] == 1'b0) begin
      q_bit   = 1'b1;
      rem_out = trial;
    end else begin
      q_bit   = 1'b0;
      rem_out = shifted;
    end
  end

endmodule

// File: rtl/shift_and_subtract_binary_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with results held until the next accepted start.
module shift_and_subtract_binary_divider
  import div_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int D = DEF_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [D-1:0] remainder,
  output logic         div_by_zero
);

  localparam int            CW         = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] COUNT_LOAD = CW'(N - 1);
  localparam logic [N-1:0]  ZERO_Q     = ZERO_DIV_QUOTIENT[N-1:0];

  state_t        state;
  logic [N-1:0]  qsh;
  logic [D:0]    rem;
  logic [CW-1:0] count;
  logic [D-1:0]  divisor_r;

  logic [D:0]    rem_next;
  logic          q_bit;
  logic [N-1:0]  qsh_next;

  restoring_div_step #(.D(D)) u_step (
    .rem_in  (rem),
    .in_bit  (qsh[N-1]),
    .divisor (divisor_r),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // Dividend bits leave from the top while quotient bits enter at the bottom.
  assign qsh_next = {qsh[N-2:0], q_bit};

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      qsh         <= '0;
      rem         <= '0;
      count       <= '0;
      divisor_r   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              done        <= 1'b1;
              quotient    <= ZERO_Q;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              qsh         <= dividend;
              rem         <= '0;
              count       <= COUNT_LOAD;
              divisor_r   <= divisor;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
              state       <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          qsh   <= qsh_next;
          rem   <= rem_next;
          count <= count - CW'(1);
          if (count == '0) begin
            quotient  <= qsh_next;
            remainder <= rem_next[D-1:0];
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            state <= CALC;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_and_subtract_binary_divider.sv
// Scoreboard bench for the shift-and-subtract divider: expected results are
// queued when an operation is issued and compared when done is observed.
module tb_shift_and_subtract_binary_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];

  shift_and_subtract_binary_divider #(.N(8), .D(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t m;
    if (b == 8'd0) begin
      m.q = 8'hFF; m.r = 8'd0; m.dbz = 1'b1;
    end else begin
      m.q = a / b; m.r = a % b; m.dbz = 1'b0;
    end
    return m;
  endfunction

  // Called at a negedge; start is sampled on the following posedge (edge k).
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    sb.push_back(model(a, b));
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Returns the number of edges from the start edge to the done cycle.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 1;
    busy_cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0", {busy, done, quotient, remainder, div_by_zero});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int c, b;
    exp_t e;
    issue(8'd100, 8'd7);
    wait_done(c, b);
    n_checks++;
    if (c !== 9) begin n_fail++; $display("FAIL basic_latency got=%0d want=9", c); end
    n_checks++;
    if (b !== 8) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d want=8", b); end
    e = sb.pop_front();
    n_checks++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_fail++;
      $display("FAIL basic_result got=%0d/%0d/%b want=%0d/%0d/%b", quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_single_pulse got=%b want=0", done); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (quotient !== 8'd14 || remainder !== 8'd2) begin
      n_fail++;
      $display("FAIL result_hold got=%0d/%0d want=14/2", quotient, remainder);
    end
  endtask

  task automatic test_corners();
    logic [7:0] a_tab [3] = '{8'd255, 8'd5, 8'd0};
    logic [7:0] b_tab [3] = '{8'd1, 8'd9, 8'd200};
    int c, b;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(a_tab[i], b_tab[i]);
      wait_done(c, b);
      e = sb.pop_front();
      n_checks++;
      if (c !== 9 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        n_fail++;
        $display("FAIL corner_%0d got=%0d/%0d/%b lat=%0d want=%0d/%0d/%b lat=9", i, quotient, remainder, div_by_zero, c, e.q, e.r, e.dbz);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int c, b;
    exp_t e;
    @(negedge clk);
    issue(8'd77, 8'd0);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL dbz_busy got=%b want=0", busy); end
    wait_done(c, b);
    n_checks++;
    if (c !== 1) begin n_fail++; $display("FAIL dbz_latency got=%0d want=1", c); end
    e = sb.pop_front();
    n_checks++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_fail++;
      $display("FAIL dbz_result got=%h/%h/%b want=%h/%h/%b", quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_hold got done=%b dbz=%b want done=0 dbz=1", done, div_by_zero);
    end
    issue(8'd77, 8'd7);
    n_checks++;
    if (div_by_zero !== 1'b0 || quotient !== 8'hFF) begin
      n_fail++;
      $display("FAIL dbz_clear_on_start got dbz=%b q=%h want dbz=0 q=ff", div_by_zero, quotient);
    end
    wait_done(c, b);
    e = sb.pop_front();
    n_checks++;
    if (c !== 9 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_fail++;
      $display("FAIL after_dbz got=%0d/%0d/%b lat=%0d want=%0d/%0d/%b lat=9", quotient, remainder, div_by_zero, c, e.q, e.r, e.dbz);
    end
  endtask

  task automatic test_ignore_start();
    int c, extra;
    exp_t e;
    @(negedge clk);
    issue(8'd200, 8'd3);
    c = 1;
    dividend = 8'd9;
    divisor  = 8'd9;
    while (done !== 1'b1 && c < 40) begin
      start = (c == 3 || c == 5) ? 1'b1 : 1'b0;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (c !== 9 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_fail++;
      $display("FAIL ignore_start got=%0d/%0d/%b lat=%0d want=%0d/%0d/%b lat=9", quotient, remainder, div_by_zero, c, e.q, e.r, e.dbz);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL no_second_done got=%0d want=0", extra); end
  endtask

  task automatic test_reset_midop();
    int c, b, stray;
    exp_t e;
    issue(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      n_fail++;
      $display("FAIL midop_reset got=%h want=0", {busy, done, quotient, remainder, div_by_zero});
    end
    stray = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    n_checks++;
    if (stray !== 0) begin n_fail++; $display("FAIL midop_no_done got=%0d want=0", stray); end
    issue(8'd100, 8'd7);
    wait_done(c, b);
    e = sb.pop_front();
    n_checks++;
    if (c !== 9 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_fail++;
      $display("FAIL after_reset got=%0d/%0d/%b lat=%0d want=%0d/%0d/%b lat=9", quotient, remainder, div_by_zero, c, e.q, e.r, e.dbz);
    end
  endtask

  task automatic test_back_to_back();
    int c, b;
    exp_t e;
    @(negedge clk);
    issue(8'd100, 8'd7);
    wait_done(c, b);
    e = sb.pop_front();
    n_checks++;
    if (c !== 9 || quotient !== e.q || remainder !== e.r) begin
      n_fail++;
      $display("FAIL b2b_first got=%0d/%0d lat=%0d want=%0d/%0d lat=9", quotient, remainder, c, e.q, e.r);
    end
    issue(8'd50, 8'd6);
    n_checks++;
    if (busy !== 1'b1 || quotient !== 8'd14 || remainder !== 8'd2) begin
      n_fail++;
      $display("FAIL b2b_accept got busy=%b q=%0d r=%0d want busy=1 q=14 r=2", busy, quotient, remainder);
    end
    wait_done(c, b);
    e = sb.pop_front();
    n_checks++;
    if (c !== 9 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_fail++;
      $display("FAIL b2b_second got=%0d/%0d/%b lat=%0d want=%0d/%0d/%b lat=9", quotient, remainder, div_by_zero, c, e.q, e.r, e.dbz);
    end
  endtask

  task automatic test_random();
    int c, b;
    logic [7:0] a, d;
    exp_t e;
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      issue(a, d);
      wait_done(c, b);
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL random_scoreboard_empty got=0 want=1");
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (c !== ((d == 8'd0) ? 1 : 9) || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
          n_fail++;
          $display("FAIL random_%0d %0d/%0d got=%0d/%0d/%b lat=%0d want=%0d/%0d/%b", i, a, d, quotient, remainder, div_by_zero, c, e.q, e.r, e.dbz);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_div_by_zero();
    test_ignore_start();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
